// File: rtl/op_arb_pkg.sv
// op_arb_pkg -- shared types for the two-requester arbitrated ALU scheduler.
//   op_e    : 3-bit opcode encoding understood by op_alu
//   state_e : scheduler FSM states (IDLE -> EXEC -> RESP -> IDLE)
package op_arb_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_SLL  = 3'd2,
        OP_SRL  = 3'd3,
        OP_SRA  = 3'd4,
        OP_EQ   = 3'd5,
        OP_GT   = 3'd6,
        OP_LAND = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/op_alu.sv
// op_alu -- purely combinational W-bit ALU.
// Ports:
//   op   : opcode (op_e)
//   a, b : operands; shifts use b[2:0] as the shift amount
//   data : arithmetic/shift result, 0 for compare-class opcodes
//   flag : carry (ADD), borrow (SUB), compare result (EQ/GT/LAND), else 0
module op_alu
    import op_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] data,
    output logic         flag
);

    logic [W:0] sum;
    logic [2:0] sh;

    assign sum = {1'b0, a} + {1'b0, b};
    assign sh  = b[2:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        data = '0;
        flag = 1'b0;
        case (op)
            OP_ADD: begin
                data = sum[W-1:0];
                flag = sum[W];
            end
            OP_SUB: begin
                data = a - b;
                flag = (a < b);
            end
            OP_SLL:  data = a << sh;
            OP_SRL:  data = a >> sh;
            OP_SRA:  data = $signed(a) >>> sh;
            OP_EQ:   flag = (a == b);
            OP_GT:   flag = ($signed(a) > $signed(b));
            OP_LAND: flag = (a != '0) && (b != '0);
            default: begin
                data = '0;
                flag = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/op_arb_sched.sv
// op_arb_sched -- arbitrates two operation requesters onto a single ALU and
// returns one result at a time under valid/ready handshaking.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid[1:0]        : request valid per requester
//   req_ready[1:0]        : one-hot accept strobe (combinational, IDLE only)
//   req_op0/1, req_a0/b0, req_a1/b1 : opcode and operands per requester
//   rsp_valid, rsp_ready  : response handshake
//   rsp_id, rsp_data, rsp_flag : responding requester and its result
//   busy                  : FSM outside IDLE
// Build option: define OP_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins contention); default build uses round-robin arbitration.
module op_arb_sched
    import op_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [2:0]   req_op0,
    input  logic [2:0]   req_op1,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_flag,
    output logic         busy
);

    state_e       state, state_nx;
    logic [1:0]   rst_sync;
    logic         run;
    logic         grant_id;
    logic [1:0]   grant;
    op_e          op_q;
    logic [W-1:0] a_q, b_q;
    logic         id_q;
    logic [W-1:0] alu_data;
    logic         alu_flag;

    // Reset release passes through two flops so accepts start cleanly
    // on the clock; assertion still takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign run = rst_sync[1];

`ifdef OP_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking.
    assign grant_id = ~req_valid[0];
`else
    logic rr_prio;  // requester favoured on the next contention

    assign grant_id = (req_valid == 2'b11) ? rr_prio : req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_prio <= 1'b0;
        end else if (grant != 2'b00) begin
            rr_prio <= ~grant_id;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        grant    = 2'b00;
        case (state)
            ST_IDLE: begin
                if (run && (req_valid != 2'b00)) begin
                    grant    = grant_id ? 2'b10 : 2'b01;
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: the operand and result registers are reset as well, because the
    // response outputs must read zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            rsp_data <= '0;
            rsp_flag <= 1'b0;
        end else begin
            if (grant != 2'b00) begin
                op_q <= op_e'(grant_id ? req_op1 : req_op0);
                a_q  <= grant_id ? req_a1 : req_a0;
                b_q  <= grant_id ? req_b1 : req_b0;
                id_q <= grant_id;
            end
            if (state == ST_EXEC) begin
                rsp_data <= alu_data;
                rsp_flag <= alu_flag;
            end
        end
    end

    op_alu #(.W(W)) u_alu (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .data (alu_data),
        .flag (alu_flag)
    );

    assign req_ready = grant;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = id_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_op_arb_sched.sv
module tb_op_arb_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [2:0]   req_op0 = 3'd0, req_op1 = 3'd0;
    logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_flag;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int last_grant = -1;  // -1: nothing granted since reset

    op_arb_sched #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Which requester should win for a given valid pattern.
    function automatic int pick(input logic [1:0] v);
`ifdef OP_ARB_FIXED_PRIO_EN
        return v[0] ? 0 : 1;
`else
        if (v == 2'b11) return (last_grant == 0) ? 1 : 0;
        return v[0] ? 0 : 1;
`endif
    endfunction

    // Result model straight from the opcode definitions, in integer arithmetic.
    function automatic void ref_alu(input int op, input longint a, input longint b,
                                    output logic [W-1:0] d, output logic f);
        longint m, sa, sb, r;
        int sh;
        m  = longint'(1) << W;
        sh = int'(b % 8);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        r  = 0;
        f  = 1'b0;
        case (op)
            0: begin r = (a + b) % m; f = ((a + b) >= m); end
            1: begin r = (a - b + m) % m; f = (a < b); end
            2: r = (a * (longint'(1) << sh)) % m;
            3: r = a / (longint'(1) << sh);
            4: r = (sa >>> sh) & (m - 1);
            5: f = (a == b);
            6: f = (sa > sb);
            default: f = (a != 0) && (b != 0);
        endcase
        d = r[W-1:0];
    endfunction

    // One complete request/response exchange with response held off for
    // `hold` cycles; checks grant, latency, result and stability.
    task automatic do_txn(input logic [1:0] v, input logic [2:0] o0, input logic [2:0] o1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input int hold, input string tag);
        int wid;
        logic [1:0] exp_ready;
        logic [W-1:0] ed;
        logic ef;
        @(negedge clk);
        req_valid = v; req_op0 = o0; req_op1 = o1;
        req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        rsp_ready = 1'b0;
        #1;
        wid = pick(v);
        exp_ready = (wid == 1) ? 2'b10 : 2'b01;
        n_checks++;
        if (req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, exp_ready);
            req_valid = 2'b00;
            repeat (4) @(negedge clk);
            rsp_ready = 1'b1;
            repeat (2) @(negedge clk);
            rsp_ready = 1'b0;
            return;
        end
        last_grant = wid;
        if (wid == 1) ref_alu(int'(o1), longint'(a1), longint'(b1), ed, ef);
        else          ref_alu(int'(o0), longint'(a0), longint'(b0), ed, ef);

        // EXEC cycle: other requests must be ignored.
        @(negedge clk);
        req_valid = 2'b11;
        req_a0 = ~a0; req_a1 = ~a1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL %s exec: ready=%b rsp_valid=%b busy=%b expected 00/0/1",
                     tag, req_ready, rsp_valid, busy);
        end

        // Response cycle N+2 and the held-off cycles after it.
        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_flag, req_ready, busy} !==
                {1'b1, wid[0], ed, ef, 2'b00, 1'b1}) begin
                n_fail++;
                $display("FAIL %s rsp c%0d: valid=%b id=%b data=%h flag=%b ready=%b busy=%b expected 1/%0d/%h/%b/00/1",
                         tag, c, rsp_valid, rsp_id, rsp_data, rsp_flag, req_ready, busy, wid, ed, ef);
            end
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s release: rsp_valid=%b busy=%b expected 0/0", tag, rsp_valid, busy);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b id=%b data=%h flag=%b busy=%b expected all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_sync: req_ready=%b expected 00", req_ready);
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        last_grant = -1;
    endtask

    task automatic test_add();
        do_txn(2'b01, 3'd0, 3'd0, 8'hF0, 8'h20, 8'h00, 8'h00, 0, "add_carry");
        do_txn(2'b10, 3'd1, 3'd1, 8'h00, 8'h00, 8'h05, 8'h09, 0, "sub_borrow");
    endtask

    task automatic test_shift();
        do_txn(2'b10, 3'd0, 3'd4, 8'h00, 8'h00, 8'b10010111, 8'd2, 0, "sra");
        do_txn(2'b10, 3'd0, 3'd2, 8'h00, 8'h00, 8'b10010111, 8'd2, 0, "sll");
        do_txn(2'b01, 3'd3, 3'd0, 8'b10010111, 8'd3, 8'h00, 8'h00, 0, "srl");
    endtask

    task automatic test_compare();
        do_txn(2'b01, 3'd6, 3'd0, 8'h80, 8'h01, 8'h00, 8'h00, 0, "gt_signed");
        do_txn(2'b01, 3'd5, 3'd0, 8'hD5, 8'hD5, 8'h00, 8'h00, 0, "eq");
        do_txn(2'b10, 3'd0, 3'd7, 8'h00, 8'h00, 8'h40, 8'h00, 0, "land_zero");
    endtask

    task automatic test_backpressure();
        do_txn(2'b11, 3'd0, 3'd1, 8'h7F, 8'h01, 8'h33, 8'h44, 5, "backpressure");
    endtask

    // Both requesters always asking, consumer always ready.
    task automatic test_back_to_back();
        int prev = -100;
        int pend_cyc = -1;
        int pend_id = 0;
        int grants = 0;
        logic [W-1:0] ed0, ed1;
        logic ef0, ef1;
        ref_alu(0, 64'h3C, 64'hD0, ed0, ef0);
        ref_alu(1, 64'h11, 64'h22, ed1, ef1);
        @(negedge clk);
        req_op0 = 3'd0; req_a0 = 8'h3C; req_b0 = 8'hD0;
        req_op1 = 3'd1; req_a1 = 8'h11; req_b1 = 8'h22;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (c == pend_cyc) begin
                n_checks++;
                if ({rsp_valid, rsp_id, rsp_data, rsp_flag} !==
                    {1'b1, pend_id[0], (pend_id == 1) ? ed1 : ed0, (pend_id == 1) ? ef1 : ef0}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp c%0d: valid=%b id=%b data=%h flag=%b expected id %0d",
                             c, rsp_valid, rsp_id, rsp_data, rsp_flag, pend_id);
                end
            end
            if (req_ready != 2'b00) begin
                int w;
                w = pick(2'b11);
                n_checks++;
                if (req_ready !== ((w == 1) ? 2'b10 : 2'b01) || (prev >= 0 && c - prev != 3)) begin
                    n_fail++;
                    $display("FAIL b2b_grant c%0d: req_ready=%b interval=%0d expected winner %0d interval 3",
                             c, req_ready, c - prev, w);
                end
                last_grant = w;
                prev = c;
                pend_cyc = c + 2;
                pend_id = w;
                grants++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (grants < 4) begin
            n_fail++;
            $display("FAIL b2b_count: grants=%0d expected at least 4", grants);
        end
        req_valid = 2'b00;
        for (int i = 0; i < 6 && busy; i++) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b expected 0", busy);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        // Grant to requester 0 so round-robin alone would favour 1 next.
        @(negedge clk);
        req_valid = 2'b01; req_op0 = 3'd0; req_a0 = 8'h12; req_b0 = 8'h34;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_grant: req_ready=%b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: ready=%b valid=%b id=%b data=%h flag=%b busy=%b expected all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_grant = -1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_rsp: rsp_valid seen %0d cycles expected 0", seen);
        end
        rsp_ready = 1'b0;
        do_txn(2'b11, 3'd0, 3'd0, 8'h01, 8'h02, 8'h03, 8'h04, 0, "rstmid_next");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn(2'($urandom_range(1, 3)), 3'($urandom), 3'($urandom),
                   W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_compare();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/op_arb_sched.md
OP_ARB_SCHED -- requirements
Module: op_arb_sched

Interface
REQ-001 Parameter: W, 8, operand/result width in bits (legal 4..32).
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 Port: req_ready  output  2  per-requester accept strobe; bit i high = request i taken this cycle.
REQ-006 Port: req_op0, req_op1  input  3 each  opcode per requester.
REQ-007 Port: req_a0, req_b0, req_a1, req_b1  input  W each  operands per requester.
REQ-008 Port: rsp_valid  output  1  response valid.
REQ-009 Port: rsp_ready  input  1  response consumer ready.
REQ-010 Port: rsp_id  output  1  requester index of current response.
REQ-011 Port: rsp_data  output  W  result.
REQ-012 Port: rsp_flag  output  1  compare result / carry-out.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 Opcodes: 0 ADD, 1 SUB, 2 SLL by b[2:0], 3 SRL, 4 SRA (signed, sign-fill), 5 EQ (a==b), 6 GT (signed a>b), 7 LAND (a!=0 && b!=0).
REQ-015 ADD: rsp_flag = carry-out of W-bit sum; SUB: rsp_flag = borrow (a<b unsigned); shifts: rsp_flag = 0, rsp_data = shifted a.
REQ-016 EQ/GT/LAND: rsp_data = 0, rsp_flag = result; any X/Z on operands is not guaranteed to produce a defined result.
REQ-017 FSM states IDLE, EXEC, RESP; IDLE->EXEC on any req_valid; EXEC->RESP unconditionally after one cycle; RESP->IDLE when rsp_ready high.
REQ-018 Grant in IDLE: req_ready one-hot for exactly one cycle to the winning requester; operands and opcode registered that cycle.
REQ-019 Arbitration is round-robin: on simultaneous req_valid=2'b11, the requester not granted last wins; first grant after reset goes to requester 0.
REQ-020 Latency: accept at cycle N -> rsp_valid high from cycle N+2, held with stable rsp_id/data/flag until rsp_ready sampled high.
REQ-021 req_ready is 0 in EXEC and RESP; no new accept until FSM returns to IDLE (one request in flight).
REQ-022 Back-to-back: acceptance possible in the cycle after the RESP->IDLE transition; minimum issue interval 3 cycles.
REQ-023 req_valid dropped by a requester before grant is legal; requester is simply skipped.

Reset
REQ-024 rst_n low forces IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flag=0, busy=0, round-robin pointer to requester 0, immediately and independent of clk.
REQ-025 Reset asserted mid-operation discards the in-flight request without response.
REQ-026 Reset release is synchronised internally; first grant earliest on second rising edge after rst_n rises.

Configuration
REQ-027 Macro OP_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority, requester 0 always wins on contention; round-robin pointer not implemented.
REQ-028 Without OP_ARB_FIXED_PRIO_EN: round-robin per REQ-019; all other behaviour identical in both builds.

Structure
REQ-029 Package op_arb_pkg holds opcode enumeration (8 codes, 3 bits) and FSM state enumeration.
REQ-030 Combinational datapath is sub-module op_alu (op, a, b -> data, flag), instantiated once; op_arb_sched holds FSM, arbiter and registers.

Verification
REQ-031 W=8, req0 ADD a=8'hF0 b=8'h20 -> req_ready=2'b01 at N, rsp_valid at N+2, data=8'h10, flag=1, id=0.
REQ-032 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; with OP_ARB_FIXED_PRIO_EN -> grants always 0.
REQ-033 req1 SRA a=8'b10010111 b=2 -> data=8'b11100101; SLL same a,b -> data=8'b01011100.
REQ-034 req0 GT a=8'h80 b=8'h01 -> flag=0, data=0; EQ a=b=8'hD5 -> flag=1.
REQ-035 rsp_ready held low 5 cycles -> rsp_valid and outputs stable, req_ready=0 throughout, busy=1.
REQ-036 rst_n pulsed low in EXEC -> all outputs 0 same cycle, no response emitted, next grant to requester 0.
